// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Latency: none (package only: types, encodings, cycle-count helpers).
// Backpressure: n/a. Users: multdiv_unit, cla_adder_32.
package multdiv_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MULT = ST_MULT,
        DIV  = ST_DIV,
        DONE = ST_DONE
    } state_t;

    // Radix-4 Booth digit; bit 2 marks a subtraction of the multiple.
    typedef enum logic [2:0] {
        BD_ZERO = 3'b000,
        BD_POS1 = 3'b001,
        BD_POS2 = 3'b010,
        BD_NEG1 = 3'b101,
        BD_NEG2 = 3'b110
    } booth_t;

    // Iteration counts as functions of the operand width.
    function automatic int mult_cycles(input int width);
        return width / 2;
    endfunction

    function automatic int div_cycles(input int width);
        return width;
    endfunction

    // Recode {b[i+1], b[i], b[i-1]} into a Booth digit.
    function automatic booth_t booth_decode(input logic [2:0] bits);
        booth_t d;
        case (bits)
            3'b001, 3'b010: d = BD_POS1;
            3'b011:         d = BD_POS2;
            3'b100:         d = BD_NEG2;
            3'b101, 3'b110: d = BD_NEG1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cla_adder_32.sv
// Carry-lookahead adder built from 8-bit blocks with block-level G/P lookahead.
// Latency: purely combinational. Backpressure: none.
// Ports: a_i, b_i (WIDTH), cin_i -> sum_o (WIDTH). WIDTH must be a multiple of 8.
module cla_adder_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o
);
    localparam int NBLK = WIDTH / 8;

    logic [WIDTH-1:0] g, p, c;
    logic [NBLK-1:0]  bg, bp;
    logic [NBLK:0]    bc;
    logic             gg, pp;

    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        gg = 1'b0;
        pp = 1'b1;
        c  = '0;
        // Block generate/propagate
        for (int k = 0; k < NBLK; k++) begin
            bg[k] = 1'b0;
            bp[k] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                bg[k] = g[8*k+i] | (p[8*k+i] & bg[k]);
                bp[k] = bp[k] & p[8*k+i];
            end
        end
        // Block carries from the lookahead terms
        bc[0] = cin_i;
        for (int k = 0; k < NBLK; k++) begin
            bc[k+1] = bg[k] | (bp[k] & bc[k]);
        end
        // In-block carries: group G/P of the lower bits applied to the block carry-in
        for (int k = 0; k < NBLK; k++) begin
            for (int i = 0; i < 8; i++) begin
                gg = 1'b0;
                pp = 1'b1;
                for (int j = 0; j < i; j++) begin
                    gg = g[8*k+j] | (p[8*k+j] & gg);
                    pp = pp & p[8*k+j];
                end
                c[8*k+i] = gg | (pp & bc[k]);
            end
        end
        sum_o = p ^ c;
    end

endmodule

// File: rtl/multdiv_unit.sv
// Sequential signed multiplier (radix-4 Booth) / divider (non-restoring) on one shared CLA.
// Latency: mult WIDTH/2+1 edges, div WIDTH+1 edges, div-by-zero 1 edge; RDY one cycle.
// Backpressure: none; a new start pulse aborts any op in flight. Divide needs MULTDIV_DIV_EN.
// Ports: clock, reset (async high), data_operandA/B, ctrl_MULT, ctrl_DIV in;
//        data_result, data_exception, data_resultRDY out.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    import multdiv_pkg::*;

    localparam int W           = WIDTH;
    // Adder is one 8-bit block wider than the operands so the two guard
    // bits of the Booth partial product / divide remainder fit.
    localparam int AW          = WIDTH + 8;
    localparam int CW          = $clog2(WIDTH) + 1;
    localparam int MULT_CYCLES = mult_cycles(WIDTH);
    localparam int DIV_CYCLES  = div_cycles(WIDTH);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    // Multiply: {partial[W+1:0], multiplier}; divide: {remainder[W+1:0], quotient}
    logic [2*W+1:0] acc_q, acc_d;
    logic           bm1_q, bm1_d;
    logic [W-1:0]   res_q, res_d;
    logic           exc_q, exc_d;

    logic [AW-1:0]  add_a, add_b, add_sum;
    logic           add_cin;
    logic [AW-1:0]  a_ext, hi_ext;
    booth_t         booth;
    logic           mult_last;
    logic [W:0]     prod_top;
    logic           sum_unused;

    assign a_ext      = {{(AW-W){a_q[W-1]}}, a_q};
    assign hi_ext     = {{(AW-W-2){acc_q[2*W+1]}}, acc_q[2*W+1:W]};
    assign booth      = booth_decode({acc_q[1:0], bm1_q});
    assign mult_last  = (cnt_q == CW'(MULT_CYCLES));
    assign prod_top   = acc_q[2*W-1:W-1];
    assign sum_unused = ^add_sum[AW-1:W+2];

`ifdef MULTDIV_DIV_EN
    logic [W-1:0]  b_q, b_d;
    logic          neg_q, neg_d, bz_q, bz_d;
    logic [AW-1:0] b_ext, opa_ext;
    logic [W+1:0]  rem_sh;
    logic          div_last, div_inv;

    assign b_ext    = {{(AW-W){b_q[W-1]}}, b_q};
    assign opa_ext  = {{(AW-W){data_operandA[W-1]}}, data_operandA};
    assign rem_sh   = {acc_q[2*W:W], acc_q[W-1]};
    assign div_last = (cnt_q == CW'(DIV_CYCLES));
    // Subtract |B| while the remainder is non-negative; a negative B flips the sense.
    assign div_inv  = ~acc_q[2*W+1] ^ b_q[W-1];
`else
    logic pend_q, pend_d;
`endif

    cla_adder_32 #(.WIDTH(AW)) u_cla (
        .a_i   (add_a),
        .b_i   (add_b),
        .cin_i (add_cin),
        .sum_o (add_sum)
    );

    // Adder operand select: one pass per cycle
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
`ifdef MULTDIV_DIV_EN
        if (!ctrl_MULT && ctrl_DIV) begin
            // |A| computed on the start edge
            add_b   = data_operandA[W-1] ? ~opa_ext : opa_ext;
            add_cin = data_operandA[W-1];
        end else
`endif
        if (state_q == MULT && !mult_last) begin
            add_a = hi_ext;
            case (booth)
                BD_POS1: add_b = a_ext;
                BD_POS2: add_b = a_ext << 1;
                BD_NEG1: begin add_b = ~a_ext;        add_cin = 1'b1; end
                BD_NEG2: begin add_b = ~(a_ext << 1); add_cin = 1'b1; end
                default: add_b = '0;
            endcase
        end
`ifdef MULTDIV_DIV_EN
        else if (state_q == DIV && div_last) begin
            // Quotient sign fix: 0 + ~q + 1
            add_b   = neg_q ? ~{{(AW-W){1'b0}}, acc_q[W-1:0]} : {{(AW-W){1'b0}}, acc_q[W-1:0]};
            add_cin = neg_q;
        end else if (state_q == DIV) begin
            add_a   = {{(AW-W-2){rem_sh[W+1]}}, rem_sh};
            add_b   = div_inv ? ~b_ext : b_ext;
            add_cin = div_inv;
        end
`endif
    end

    // Next-state / datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        bm1_d   = bm1_q;
        res_d   = res_q;
        exc_d   = exc_q;
`ifdef MULTDIV_DIV_EN
        b_d     = b_q;
        neg_d   = neg_q;
        bz_d    = bz_q;
`else
        pend_d  = pend_q;
`endif
        case (state_q)
            IDLE: begin
`ifndef MULTDIV_DIV_EN
                // Divide not built: answer a divide request as divide-by-zero
                if (pend_q) begin
                    res_d   = '0;
                    exc_d   = 1'b1;
                    pend_d  = 1'b0;
                    state_d = DONE;
                end
`endif
            end
            MULT: begin
                if (mult_last) begin
                    res_d   = acc_q[W-1:0];
                    exc_d   = ~((&prod_top) | ~(|prod_top));
                    state_d = DONE;
                end else begin
                    acc_d = {{2{add_sum[W+1]}}, add_sum[W+1:0], acc_q[W-1:2]};
                    bm1_d = acc_q[1];
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef MULTDIV_DIV_EN
            DIV: begin
                if (bz_q) begin
                    res_d   = '0;
                    exc_d   = 1'b1;
                    state_d = DONE;
                end else if (div_last) begin
                    res_d   = add_sum[W-1:0];
                    // Only MIN / -1 yields a positive quotient with the top bit set
                    exc_d   = acc_q[W-1] & ~neg_q;
                    state_d = DONE;
                end else begin
                    acc_d = {add_sum[W+1:0], acc_q[W-2:0], ~add_sum[W+1]};
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Start pulses override everything; MULT wins a tie
        if (ctrl_MULT) begin
            state_d = MULT;
            cnt_d   = '0;
            a_d     = data_operandA;
            acc_d   = {{(W+2){1'b0}}, data_operandB};
            bm1_d   = 1'b0;
`ifndef MULTDIV_DIV_EN
            pend_d  = 1'b0;
`endif
        end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
            state_d = DIV;
            cnt_d   = '0;
            acc_d   = {{(W+2){1'b0}}, add_sum[W-1:0]};
            b_d     = data_operandB;
            neg_d   = data_operandA[W-1] ^ data_operandB[W-1];
            bz_d    = (data_operandB == '0);
`else
            state_d = IDLE;
            pend_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            bm1_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
            b_q     <= '0;
            neg_q   <= 1'b0;
            bz_q    <= 1'b0;
`else
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            bm1_q   <= bm1_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
`ifdef MULTDIV_DIV_EN
            b_q     <= b_d;
            neg_q   <= neg_d;
            bz_q    <= bz_d;
`else
            pend_q  <= pend_d;
`endif
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Sequential signed multiplier/divider that sits beside the ALU in the execute stage. Each cycle it drives its partial-product or partial-remainder datapath through one shared carry-lookahead adder. The processor stalls while the unit is busy. The unit pulses `data_resultRDY` when the result is valid, and flags overflow or divide-by-zero on `data_exception`.

## Interface
- `WIDTH`, default 32: operand/result width; must be a multiple of 8 (the CLA adder is built from 8-bit blocks) and even.
- `clock`  in  1  sole clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_operandA`  in  WIDTH  multiplicand / dividend, two's complement.
- `data_operandB`  in  WIDTH  multiplier / divisor, two's complement.
- `ctrl_MULT`  in  1  one-cycle start pulse for multiply; operands sampled on the same edge.
- `ctrl_DIV`  in  1  one-cycle start pulse for divide; operands sampled on the same edge.
- `data_result`  out  WIDTH  product (low WIDTH bits) or quotient.
- `data_exception`  out  1  overflow / divide-by-zero flag, valid with `data_result`.
- `data_resultRDY`  out  1  high for exactly one cycle when the result is valid.

## Operation
- States: `IDLE`, `MULT`, `DIV`, `DONE`. Reset → `IDLE`; `data_result`=0, `data_exception`=0, `data_resultRDY`=0.
- `ctrl_MULT` in any state: latch operands, clear counter, go to `MULT`. This also aborts any op in flight, which never asserts RDY.
- `ctrl_DIV` in any state: same behaviour, going to `DIV`. If both pulses arrive together, MULT wins.
- MULT: radix-4 modified Booth.
  - One recoded digit {−2,−1,0,+1,+2}·A added per cycle into a 2·WIDTH+2-bit accumulator, then arithmetic shift right by 2.
  - WIDTH/2 iterations.
  - `data_result` = low WIDTH bits of the product.
  - `data_exception`=1 iff the upper WIDTH+1 product bits are not all equal (signed overflow).
- DIV: non-restoring on magnitudes |A|, |B|.
  - WIDTH iterations, one add/subtract per cycle.
  - Final sign fix: quotient negated iff sign(A)≠sign(B). Truncation toward zero; remainder discarded.
  - B=0: skip iteration, go straight to `DONE`; result 0, exception 1.
  - A=most-negative, B=−1: result = most-negative (0x80000000 at WIDTH=32), exception 1.
- `DONE`: RDY=1 for one cycle, then → `IDLE`. `data_result`/`data_exception` hold until the next start pulse or reset.
- While in `MULT`/`DIV`, outputs keep the previous result; RDY=0.

## Timing
- Start pulse sampled at edge 0.
- Multiply: RDY high in the cycle after edge WIDTH/2+1 (17 at WIDTH=32).
- Divide: RDY high in the cycle after edge WIDTH+1 (33).
- Divide-by-zero: RDY high in the cycle after edge 1.
- Result and exception are registered; they update on the same edge that raises RDY.
- A start pulse in the `DONE` cycle is honoured: RDY still shows for that cycle, and the new op begins.
- Reset mid-operation: outputs clear asynchronously, → `IDLE`, no RDY.
- One adder pass per cycle. The critical path is mux → WIDTH-bit CLA → register; no other chained arithmetic.

## Configuration
- `MULTDIV_DIV_EN` defined: full behaviour as above.
- Not defined:
  - Divide datapath and `DIV` state are removed.
  - `ctrl_DIV` → `DONE` next cycle with result 0, exception 1 (same timing as divide-by-zero).
  - `ctrl_MULT` behaviour is unchanged.

## Structure
- Shared package `multdiv_pkg`:
  - state encoding localparams.
  - Booth-digit encoding.
  - `MULT_CYCLES`=WIDTH/2, `DIV_CYCLES`=WIDTH.
- Sub-module `cla_adder_32`:
  - WIDTH-bit carry-lookahead adder, 8-bit blocks plus block-level G/P lookahead, carry-in.
  - Instantiated once and time-shared between multiply and divide.
  - Subtraction = inverted operand + carry-in 1.
- Top holds the FSM, counter, operand/accumulator registers and sign-fix logic.

## Test plan
- A=7, B=−3, ctrl_MULT at edge 0 → RDY only in cycle after edge 17, result 0xFFFFFFEB, exception 0.
- A=0x00010000, B=0x00010000, multiply → result 0x00000000, exception 1.
- A=−100, B=7, ctrl_DIV → RDY after edge 33, result 0xFFFFFFF2 (−14), exception 0; A=0x80000000, B=−1 → 0x80000000, exception 1.
- A=5, B=0, ctrl_DIV → RDY after edge 1, result 0, exception 1; repeated with `MULTDIV_DIV_EN` undefined and B=3 → same response.
- ctrl_DIV at edge 0, then ctrl_MULT with A=6, B=7 at edge 5 → single RDY after edge 22, result 42, no divide RDY.
- ctrl_MULT at edge 0, reset asserted mid-cycle 8 → outputs 0 immediately, no RDY through cycle 40; the next multiply of 3×3 gives 9.
